// File: rtl/arith_pkg.sv
// Shared arithmetic constants and types for the serial
// multiplier/divider set.
package arith_pkg;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_e;

endpackage

// File: rtl/serial_divider32_if.sv
// Handshake and data bundle for the bit-serial divider.
interface serial_divider32_if #(
    parameter int WIDTH = arith_pkg::DIV_WIDTH
);

    logic             start;
    logic             dividend_bit;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             quotient_bit;
    logic             quotient_valid;
    logic             done;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend_bit,
        output divisor,
        input  busy,
        input  quotient_bit,
        input  quotient_valid,
        input  done,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend_bit,
        input  divisor,
        output busy,
        output quotient_bit,
        output quotient_valid,
        output done,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, then
// subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             q
);

    logic [WIDTH:0] t;

    assign t = {r, in_bit};
    assign q = (t >= {1'b0, divisor});

    // Result is below the divisor, so WIDTH-bit wraparound is exact
    assign r_next = t[WIDTH-1:0] - (q ? divisor : '0);

endmodule

// File: rtl/serial_divider32.sv
// Bit-serial restoring divider: serial dividend in, serial
// quotient out, parallel remainder at completion.
module serial_divider32
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic                clk,
    input logic                rst,
    serial_divider32_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_q;
    div_state_e       state_d;
    logic             accept;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last;
    logic [WIDTH-1:0] r_next;
    logic             q;
    logic             qbit_q;
    logic             qvalid_q;
    logic             dbz_q;
    logic [WIDTH-1:0] rem_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r       (r_q),
        .in_bit  (bus.dividend_bit),
        .divisor (dvs_q),
        .r_next  (r_next),
        .q       (q)
    );

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                accept  = bus.start;
                state_d = bus.start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q      <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            qbit_q   <= 1'b0;
            qvalid_q <= 1'b0;
            dbz_q    <= 1'b0;
            rem_q    <= '0;
        end else begin
            qvalid_q <= (state_q == RUN);
            if (state_q == RUN) begin
                r_q    <= r_next;
                qbit_q <= q;
                cnt_q  <= cnt_q + CNT_W'(1);
                if (last) begin
                    rem_q <= r_next;
                end
            end
            if (accept) begin
                dvs_q <= bus.divisor;
                r_q   <= '0;
                cnt_q <= '0;
                dbz_q <= (bus.divisor == '0);
            end
        end
    end

    assign bus.busy           = (state_q == RUN);
    assign bus.done           = (state_q == FIN);
    assign bus.quotient_bit   = qbit_q;
    assign bus.quotient_valid = qvalid_q;
    assign bus.remainder      = rem_q;
    assign bus.div_by_zero    = dbz_q;

endmodule

// File: tb/tb_serial_divider32.sv
// Directed and randomized checks of serial_divider32 against
// plain integer division.
module tb_serial_divider32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    serial_divider32_if #(.WIDTH(32)) bus ();

    serial_divider32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge just after the start cycle.
    task automatic feed(
        input  logic [31:0] a,
        input  int          pulse_at,
        input  logic [31:0] pulse_div,
        input  bit          chain,
        input  logic [31:0] next_div,
        output logic [31:0] q,
        output int          nvalid,
        output bit          done_ok,
        output logic [31:0] rem,
        output logic        dbz,
        output bit          post_ok
    );
        q = '0;
        nvalid = 0;
        done_ok = 1'b1;
        rem = 'x;
        dbz = 1'bx;
        for (int i = 0; i < 32; i++) begin
            bus.dividend_bit = a[31-i];
            bus.start = (i == pulse_at);
            if (i == pulse_at) bus.divisor = pulse_div;
            @(negedge clk);
            if (bus.quotient_valid) begin
                q = {q[30:0], bus.quotient_bit};
                nvalid++;
            end
            if (i == 31) begin
                if (!(bus.done && bus.quotient_valid && !bus.busy)) done_ok = 1'b0;
                rem = bus.remainder;
                dbz = bus.div_by_zero;
            end else if (bus.done) begin
                done_ok = 1'b0;
            end
        end
        bus.start = chain;
        bus.divisor = next_div;
        bus.dividend_bit = 1'b0;
        @(negedge clk);
        post_ok = !bus.done && !bus.quotient_valid;
        if (chain) post_ok = post_ok && bus.busy;
        bus.start = 1'b0;
    endtask

    task automatic begin_op(input logic [31:0] b);
        bus.start = 1'b1;
        bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] rem;
        logic        dbz;
        int          nv;
        bit          dok;
        bit          pok;
        begin_op(b);
        feed(a, -1, '0, 1'b0, b, q, nv, dok, rem, dbz, pok);
        chk({tag, ".quot"}, q, ref_q(a, b));
        chk({tag, ".rem"}, rem, ref_r(a, b));
        chk({tag, ".nvalid"}, 32'(nv), 32'd32);
        chk({tag, ".done"}, {31'd0, dok}, 32'd1);
        chk({tag, ".dbz"}, {31'd0, dbz}, {31'd0, b == 0});
        chk({tag, ".post"}, {31'd0, pok}, 32'd1);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] rem;
        logic        dbz;
        int          nv;
        bit          dok;
        bit          pok;
        logic [31:0] a;
        logic [31:0] b;

        bus.start = 1'b0;
        bus.dividend_bit = 1'b0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.qv", {31'd0, bus.quotient_valid}, 32'd0);
        chk("rst.done", {31'd0, bus.done}, 32'd0);
        chk("rst.rem", bus.remainder, 32'd0);
        chk("rst.dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", {31'd0, bus.busy}, 32'd0);

        run_check("d100_7", 32'd100, 32'd7);
        chk("d100_7.lit", ref_q(32'd100, 32'd7), 32'h0000_000E);
        run_check("dff_1", 32'hFFFF_FFFF, 32'd1);
        run_check("d3_10", 32'd3, 32'd10);
        run_check("d5_0", 32'd5, 32'd0);

        repeat (3) @(negedge clk);
        chk("hold.rem", bus.remainder, 32'd5);
        chk("hold.dbz", {31'd0, bus.div_by_zero}, 32'd1);

        // ignored restart mid-run, then back-to-back start in FIN
        begin_op(32'd9);
        feed(32'd12345, 5, 32'd3, 1'b1, 32'd10, q, nv, dok, rem, dbz, pok);
        chk("busy.quot", q, 32'd12345 / 32'd9);
        chk("busy.rem", rem, 32'd12345 % 32'd9);
        chk("busy.done", {31'd0, dok}, 32'd1);
        chk("chain.gap", {31'd0, pok}, 32'd1);
        feed(32'd1000, -1, '0, 1'b0, '0, q, nv, dok, rem, dbz, pok);
        chk("chain.quot", q, 32'd100);
        chk("chain.rem", rem, 32'd0);
        chk("chain.nvalid", 32'(nv), 32'd32);
        chk("chain.done", {31'd0, dok}, 32'd1);

        // async reset in the middle of a divide-by-zero run
        begin_op(32'd0);
        for (int i = 0; i < 10; i++) begin
            bus.dividend_bit = i[0];
            @(negedge clk);
        end
        chk("pre.dbz", {31'd0, bus.div_by_zero}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", {31'd0, bus.busy}, 32'd0);
        chk("arst.qv", {31'd0, bus.quotient_valid}, 32'd0);
        chk("arst.qbit", {31'd0, bus.quotient_bit}, 32'd0);
        chk("arst.done", {31'd0, bus.done}, 32'd0);
        chk("arst.dbz", {31'd0, bus.div_by_zero}, 32'd0);
        chk("arst.rem", bus.remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst.idle", {31'd0, bus.busy}, 32'd0);
        run_check("d42_6", 32'd42, 32'd6);

        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            unique case (n % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = a >> $urandom_range(0, 31);
                default: b = (n == 7) ? 32'd0 : 32'($urandom_range(1, 65535));
            endcase
            run_check($sformatf("rnd%0d", n), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
